// File: rtl/switch_pulse_monitor_if.sv
// switch_pulse_monitor_if: control, limit and result signals of the pulse monitor
interface switch_pulse_monitor_if #(parameter int N = 4);
    logic         en;
    logic         pulse_in;
    logic [N-1:0] min_width;
    logic [N-1:0] max_width;
    logic [N-1:0] width;
    logic [N-1:0] period;
    logic         valid;
    logic         err_short;
    logic         err_long;
    logic         overflow;
    modport master (
        output en, pulse_in, min_width, max_width,
        input  width, period, valid, err_short, err_long, overflow
    );
    modport slave (
        input  en, pulse_in, min_width, max_width,
        output width, period, valid, err_short, err_long, overflow
    );
endinterface

// File: rtl/switch_pulse_monitor.sv
// switch_pulse_monitor: measures high width and period of a looped-back switch pulse and checks width limits
module switch_pulse_monitor #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  reset,
    switch_pulse_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;
    logic [N-1:0]           w_cnt, p_cnt, width_lat;
    logic                   ovf;
    logic                   s, rise, w_max, p_max;
    logic [N-1:0]           w_sat, p_sat;
    assign s     = sync[SYNC_STAGES-1];
    assign rise  = s & ~s_d;
    assign w_max = &w_cnt;
    assign p_max = &p_cnt;
    assign w_sat = w_max ? w_cnt : w_cnt + ONE;
    assign p_sat = p_max ? p_cnt : p_cnt + ONE;
    // Synchroniser chain and one-cycle delayed copy for edge detection; runs regardless of en
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.pulse_in};
            s_d  <= s;
        end
    end
    // Measurement FSM: counters run rise-to-rise, results and flags publish on the closing rise
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            w_cnt         <= '0;
            p_cnt         <= '0;
            width_lat     <= '0;
            ovf           <= 1'b0;
            bus.width     <= '0;
            bus.period    <= '0;
            bus.valid     <= 1'b0;
            bus.err_short <= 1'b0;
            bus.err_long  <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.valid     <= 1'b0;
            bus.err_short <= 1'b0;
            bus.err_long  <= 1'b0;
            bus.overflow  <= 1'b0;
            if (!bus.en) begin
                state     <= IDLE;
                w_cnt     <= '0;
                p_cnt     <= '0;
                width_lat <= '0;
                ovf       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        w_cnt <= ONE;
                        p_cnt <= ONE;
                        ovf   <= 1'b0;
                        state <= HIGH;
                    end
                    HIGH: if (s) begin
                        w_cnt <= w_sat;
                        p_cnt <= p_sat;
                        ovf   <= ovf | w_max | p_max;
                    end else begin
                        width_lat <= w_cnt;
                        p_cnt     <= p_sat;
                        ovf       <= ovf | p_max;
                        state     <= LOW;
                    end
                    LOW: if (rise) begin
                        bus.width     <= width_lat;
                        bus.period    <= p_cnt;
                        bus.err_short <= width_lat < bus.min_width;
                        bus.err_long  <= width_lat > bus.max_width;
                        bus.overflow  <= ovf;
                        bus.valid     <= 1'b1;
                        w_cnt         <= ONE;
                        p_cnt         <= ONE;
                        ovf           <= 1'b0;
                        state         <= HIGH;
                    end else begin
                        p_cnt <= p_sat;
                        ovf   <= ovf | p_max;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_switch_pulse_monitor.sv
// tb_switch_pulse_monitor: directed pulse trains with hand-computed width/period/flag expectations
module tb_switch_pulse_monitor;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vcnt = 0;
    int   flag_leak = 0;
    int   cyc = 0;
    int   last_v = 0;
    int   prev_v = 0;
    logic [3:0] l_width, l_period;
    logic l_es, l_el, l_ov;
    switch_pulse_monitor_if #(.N(4)) bus ();
    switch_pulse_monitor #(.N(4), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Capture every valid strobe just after the edge; flags seen without valid are counted as leaks
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.valid) begin
            vcnt++;
            prev_v = last_v;
            last_v = cyc;
            l_width = bus.width;
            l_period = bus.period;
            l_es = bus.err_short;
            l_el = bus.err_long;
            l_ov = bus.overflow;
        end else if (bus.err_short | bus.err_long | bus.overflow) begin
            flag_leak++;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulses(input int h, input int l, input int k);
        for (int i = 0; i < k; i++) begin
            bus.pulse_in = 1'b1;
            cycles(h);
            bus.pulse_in = 1'b0;
            cycles(l);
        end
    endtask
    task automatic chk_last(input string tag, input int w, input int p, input int es, input int el, input int ov);
        chk({tag, "_width"}, 32'(l_width), w);
        chk({tag, "_period"}, 32'(l_period), p);
        chk({tag, "_err_short"}, 32'(l_es), es);
        chk({tag, "_err_long"}, 32'(l_el), el);
        chk({tag, "_overflow"}, 32'(l_ov), ov);
    endtask
    initial begin
        reset = 1'b1;
        bus.en = 1'b1;
        bus.pulse_in = 1'b0;
        bus.min_width = 4'd2;
        bus.max_width = 4'd6;
        cycles(3);
        reset = 1'b0;
        bus.pulse_in = 1'b1;
        cycles(4);
        reset = 1'b1;
        bus.pulse_in = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(1);
        chk("rst_width", 32'(bus.width), 0);
        chk("rst_period", 32'(bus.period), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_flags", 32'({bus.err_short, bus.err_long, bus.overflow}), 0);
        vcnt = 0;
        pulses(3, 5, 1);
        chk("first_rise_no_valid", vcnt, 0);
        pulses(3, 5, 3);
        chk("nominal_count", vcnt, 3);
        chk_last("nominal", 3, 8, 0, 0, 0);
        chk("nominal_interval", last_v - prev_v, 8);
        vcnt = 0;
        pulses(1, 4, 3);
        chk("short_count", vcnt, 3);
        chk_last("short", 1, 5, 1, 0, 0);
        chk("short_interval", last_v - prev_v, 5);
        pulses(7, 3, 3);
        chk_last("long", 7, 10, 0, 1, 0);
        pulses(20, 2, 3);
        chk_last("sat", 15, 15, 0, 1, 1);
        pulses(4, 4, 2);
        chk_last("pre_en", 4, 8, 0, 0, 0);
        bus.pulse_in = 1'b1;
        cycles(3);
        bus.pulse_in = 1'b0;
        cycles(2);
        vcnt = 0;
        bus.en = 1'b0;
        cycles(3);
        chk("en_low_valid", 32'(bus.valid), 0);
        bus.en = 1'b1;
        cycles(2);
        pulses(3, 5, 1);
        chk("en_resume_no_valid", vcnt, 0);
        chk("en_hold_width", 32'(bus.width), 4);
        chk("en_hold_period", 32'(bus.period), 8);
        pulses(3, 5, 1);
        chk("en_resume_count", vcnt, 1);
        chk_last("resume", 3, 8, 0, 0, 0);
        bus.min_width = 4'd9;
        bus.max_width = 4'd1;
        pulses(5, 3, 2);
        chk_last("inverted_limits", 5, 8, 1, 1, 0);
        chk("flags_without_valid", flag_leak, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
